uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

Standalone UART receiver for the Nexys 4 designs: it recovers 8N1 bytes from the PC on `RXD` and holds each byte for a consumer until that consumer acknowledges it. It is the receive-side counterpart of the periodic switch-to-PC transmitter path. It replaces the bare receive half of the combined transceiver wherever the fabric needs framing-error and overrun visibility and a read handshake.

## Interface
- `CLKS_PER_BIT`, default 10417: clock cycles per bit. The default gives 9600 baud at 100 MHz. The minimum legal value is 4.
- `CLK100MHZ`  in  1  system clock; all logic is on the rising edge.
- `CPU_RESETN`  in  1  reset, synchronous and active-low.
- `RXD`  in  1  serial line from the PC. It is asynchronous and idles high.
- `RD`  in  1  consumer acknowledge. It is sampled only while `RX_valid` = 1.
- `DOUT`  out  8  last good received byte.
- `RX_valid`  out  1  `DOUT` holds an unread byte.
- `frame_err`  out  1  one-cycle pulse when a bad stop bit is detected.
- `overrun`  out  1  sticky flag: an unread byte was overwritten.

## Operation
- `RXD` passes through a 2-flop synchronizer (`rxs`) before any use. The synchronizer flops reset to 1.
- The FSM has four states: IDLE, START, DATA, STOP, plus BREAK.
  - IDLE: when `rxs` = 0, load the bit counter `cnt` with 0 and go to START.
  - START: when `cnt` = `CLKS_PER_BIT`/2 (integer division):
    - if `rxs` = 0, clear `cnt` and go to DATA with bit index 0;
    - if `rxs` = 1, treat it as a false start and return to IDLE with no output change.
  - DATA: when `cnt` = `CLKS_PER_BIT`-1, clear `cnt` and shift `rxs` into the shift register, LSB first. After bit index 7, go to STOP.
  - STOP: when `cnt` = `CLKS_PER_BIT`-1, sample `rxs`:
    - 1: the byte is good; go to IDLE.
    - 0: framing error; pulse `frame_err`, leave `DOUT`/`RX_valid`/`overrun` untouched, and go to BREAK.
  - BREAK: wait until `rxs` = 1, then go to IDLE. This blocks re-triggering on a held-low line.
- Good-byte delivery happens on the STOP sample edge:
  - `DOUT` ← shift register and `RX_valid` ← 1.
  - If `RX_valid` was already 1 and `RD` = 0 in that cycle, set `overrun` ← 1. The old byte is lost and `DOUT` takes the new byte.
  - If `RD` = 1 in that same cycle, the new byte is loaded, `RX_valid` stays 1, and `overrun` is not set.
- Read handshake: `RD` = 1 while `RX_valid` = 1 and no delivery is occurring clears `RX_valid` and `overrun` on the next edge.
  - `DOUT` keeps its value after the read.
  - `RD` while `RX_valid` = 0 is ignored.
- `cnt` width is clog2(`CLKS_PER_BIT`). The counter never wraps past `CLKS_PER_BIT`-1.

## Timing
- Reset values: `DOUT` = 8'h00, `RX_valid` = 0, `frame_err` = 0, `overrun` = 0; FSM in IDLE; `cnt` = 0; synchronizer = 2'b11.
- Reset asserted mid-frame returns the block to IDLE on the next edge. The partial byte is discarded and no flag is raised. After release, a line still low mid-frame is treated as a new start bit.
- Let T0 be the edge at which IDLE sees `rxs` = 0; this is 2 cycles after the pin falls.
- Start confirmation occurs at T0 + `CLKS_PER_BIT`/2.
- Bit k is sampled at T0 + `CLKS_PER_BIT`/2 + (k+1)·`CLKS_PER_BIT`, for k = 0..7.
- The stop bit is sampled at T0 + `CLKS_PER_BIT`/2 + 9·`CLKS_PER_BIT`. `RX_valid` and `DOUT` update on that edge; `frame_err` is high for exactly that one cycle.
- Back-to-back frames are accepted: IDLE is re-entered at stop-bit mid-point, so the next start edge may follow immediately.
- Sampling tolerance is ±4% baud mismatch at the default setting.

## Test plan
- Single byte: `CLKS_PER_BIT` = 16, send 0xA5 8N1, `RD` held 0. Required: `RX_valid` rises exactly at T0+8+144 with `DOUT` = 0xA5; `frame_err` and `overrun` stay 0.
- Handshake: after the first test, pulse `RD` for 1 cycle. Required: `RX_valid` = 0 on the next cycle and `DOUT` remains 0xA5. A further `RD` pulse is ignored.
- Overrun: send 0x3C then 0xC3 back-to-back with no `RD`. Required: `DOUT` = 0xC3, `RX_valid` = 1, `overrun` = 1. Then `RD` clears both flags. Repeat with `RD` asserted exactly on the second stop-sample cycle. Required: `overrun` stays 0 and `DOUT` = 0xC3.
- Framing error: send 0x55 with stop bit 0, then hold the line low for 40 cycles, then release. Required:
  - `frame_err` high for one cycle at the stop sample;
  - `RX_valid` and `DOUT` unchanged;
  - no new start is detected until the line returns high;
  - a following 0x0F is received correctly.
- Glitch/false start: drive `RXD` low for 5 cycles. Required: the FSM returns to IDLE and no output changes.
- Reset mid-frame: assert `CPU_RESETN` = 0 during bit 4 of 0xFF. Required: all outputs at reset values on the next edge. After release with the line high, a subsequent 0x81 is received correctly.

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver with framing-error pulse, sticky overrun and read handshake
module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       RXD,
    input  logic       RD,
    output logic [7:0] DOUT,
    output logic       RX_valid,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    // cnt is cleared on the IDLE edge, so half a bit has elapsed when it reaches MID
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;
    logic [1:0]    sync;
    logic          rxs;
    logic          tick;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sr;
    assign rxs  = sync[1];
    assign tick = cnt == LAST;
    always_ff @(posedge CLK100MHZ) begin
        if (!CPU_RESETN) begin
            sync      <= 2'b11;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sr        <= '0;
            DOUT      <= '0;
            RX_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync      <= {sync[0], RXD};
            frame_err <= 1'b0;
            cnt       <= (state == IDLE || state == BREAK || tick) ? '0 : cnt + 1'b1;
            if (RD && RX_valid) begin
                RX_valid <= 1'b0;
                overrun  <= 1'b0;
            end
            case (state)
                IDLE: if (!rxs) state <= START;
                START: if (cnt == MID) begin
                    cnt   <= '0;
                    idx   <= '0;
                    state <= rxs ? IDLE : DATA;
                end
                DATA: if (tick) begin
                    sr  <= {rxs, sr[7:1]};
                    idx <= idx + 1'b1;
                    if (idx == 3'd7) state <= STOP;
                end
                STOP: if (tick) begin
                    if (rxs) begin
                        DOUT     <= sr;
                        RX_valid <= 1'b1;
                        if (RX_valid && !RD) overrun <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                    end
                end
                BREAK: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed and randomized frames against a transaction-level receiver model
module tb_uart_byte_rx;
    localparam int CPB = 16;
    // pin edge -> two synchronizer flops -> IDLE edge, then half a bit plus nine bits
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;
    logic       CLK100MHZ = 1'b0;
    logic       CPU_RESETN;
    logic       RXD;
    logic       RD;
    logic [7:0] DOUT;
    logic       RX_valid;
    logic       frame_err;
    logic       overrun;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_start = 0;
    int rise_cyc = -1;
    int fe_cyc = -1;
    int fe_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] m_dout;
    logic m_valid;
    logic m_ovr;

    uart_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK100MHZ(CLK100MHZ),
        .CPU_RESETN(CPU_RESETN),
        .RXD(RXD),
        .RD(RD),
        .DOUT(DOUT),
        .RX_valid(RX_valid),
        .frame_err(frame_err),
        .overrun(overrun)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;
    always @(negedge CLK100MHZ) begin
        if (RX_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = RX_valid;
        if (frame_err) begin
            fe_cyc = cyc;
            fe_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_dout"}, {24'd0, DOUT}, {24'd0, m_dout});
        check({tag, "_valid"}, {31'd0, RX_valid}, {31'd0, m_valid});
        check({tag, "_ovr"}, {31'd0, overrun}, {31'd0, m_ovr});
    endtask

    function automatic void m_deliver(input logic [7:0] b, input logic rd);
        m_ovr   = (m_valid && !rd) ? 1'b1 : (rd ? 1'b0 : m_ovr);
        m_dout  = b;
        m_valid = 1'b1;
    endfunction

    function automatic void m_read();
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
    endfunction

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        last_start = cyc;
        for (int i = 0; i < 10; i++) begin
            RXD = f[i];
            repeat (CPB) @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic rd_pulse();
        RD = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        RD = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK100MHZ);
        #1;
    endtask

    initial begin
        int s1, fe0, r0;
        logic [7:0] b;
        logic was_valid;
        RXD = 1'b1;
        RD = 1'b0;
        CPU_RESETN = 1'b0;
        m_dout = 8'h00;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        idle(3);
        check_state("reset");
        check("reset_fe", {31'd0, frame_err}, 32'd0);
        CPU_RESETN = 1'b1;
        idle(5);
        send(8'hA5, 1'b1);
        m_deliver(8'hA5, 1'b0);
        check_state("single");
        check("single_rise", rise_cyc, last_start + LAT);
        check("single_fe", fe_cnt, 0);
        rd_pulse();
        m_read();
        check_state("hs_read");
        rd_pulse();
        m_read();
        check_state("hs_ignored");
        send(8'h3C, 1'b1);
        s1 = last_start;
        send(8'hC3, 1'b1);
        m_deliver(8'h3C, 1'b0);
        m_deliver(8'hC3, 1'b0);
        check_state("ovr");
        check("ovr_rise", rise_cyc, s1 + LAT);
        rd_pulse();
        m_read();
        check_state("ovr_clear");
        fork
            begin
                send(8'h3C, 1'b1);
                send(8'hC3, 1'b1);
            end
            begin
                repeat (10 * CPB + LAT - 1) @(posedge CLK100MHZ);
                #1 RD = 1'b1;
                @(posedge CLK100MHZ);
                #1 RD = 1'b0;
            end
        join
        m_deliver(8'h3C, 1'b0);
        m_deliver(8'hC3, 1'b1);
        check_state("ovr_rd");
        rd_pulse();
        m_read();
        check_state("ovr_rd_clear");
        send(8'h99, 1'b1);
        m_deliver(8'h99, 1'b0);
        fe0 = fe_cnt;
        send(8'h55, 1'b0);
        check("fe_count", fe_cnt, fe0 + 1);
        check("fe_time", fe_cyc, last_start + LAT);
        check_state("fe_hold");
        idle(40);
        check("fe_break_count", fe_cnt, fe0 + 1);
        check_state("fe_break");
        RXD = 1'b1;
        idle(20);
        send(8'h0F, 1'b1);
        m_deliver(8'h0F, 1'b0);
        check_state("fe_next");
        rd_pulse();
        m_read();
        check_state("fe_next_read");
        fe0 = fe_cnt;
        r0 = rise_cyc;
        RXD = 1'b0;
        idle(5);
        RXD = 1'b1;
        idle(30);
        check_state("glitch");
        check("glitch_fe", fe_cnt, fe0);
        check("glitch_rise", rise_cyc, r0);
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            idle($urandom_range(0, 20));
            was_valid = m_valid;
            send(b, 1'b1);
            m_deliver(b, 1'b0);
            check_state("rand");
            if (!was_valid) check("rand_rise", rise_cyc, last_start + LAT);
            if ($urandom_range(0, 1) == 1) begin
                rd_pulse();
                m_read();
                check_state("rand_read");
            end
        end
        send(8'h42, 1'b1);
        m_deliver(8'h42, 1'b0);
        fork
            send(8'hFF, 1'b1);
            begin
                repeat (5 * CPB + 8) @(posedge CLK100MHZ);
                #1 CPU_RESETN = 1'b0;
                @(posedge CLK100MHZ);
                #1;
                m_dout = 8'h00;
                m_valid = 1'b0;
                m_ovr = 1'b0;
                check_state("midrst");
                check("midrst_fe", {31'd0, frame_err}, 32'd0);
                CPU_RESETN = 1'b1;
            end
        join
        idle(10);
        send(8'h81, 1'b1);
        m_deliver(8'h81, 1'b0);
        check_state("after_rst");
        check("after_rst_rise", rise_cyc, last_start + LAT);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
